// File: rtl/button_io_pkg.sv
// Shared constants for the button_io peripheral: register offsets, default base
// address and a population-count helper used for the press counter.
package button_io_pkg;

  localparam logic [7:0] DEFAULT_BASE_ADDR = 8'hE0;

  localparam logic [1:0] OFF_LEVEL  = 2'd0;
  localparam logic [1:0] OFF_EVENT  = 2'd1;
  localparam logic [1:0] OFF_IRQ_EN = 2'd2;
  localparam logic [1:0] OFF_COUNT  = 2'd3;

  function automatic logic [7:0] count_ones(input logic [7:0] v);
    logic [7:0] n;
    n = 8'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Single-button conditioner: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle pulse on each accepted rising level.
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter int CNT_W           = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;

  // Synchronise, count consecutive disagreeing cycles and toggle once stable
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt   <= {CNT_W{1'b0}};
        r_press <= 1'b0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= {CNT_W{1'b0}};
        r_level <= ~r_level;
        r_press <= ~r_level;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_press <= 1'b0;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/button_io.sv
// Bus-mapped push-button peripheral: debounced levels, sticky press events,
// press counter and an enable-gated interrupt with acknowledge.
module button_io
  import button_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int         N_BTN           = 2,
  parameter int         DEBOUNCE_CYCLES = 65535,
  parameter int         CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  inout  wire  [7:0]       BUS_DATA,
  input  logic [7:0]       BUS_ADDR,
  input  logic             BUS_WE,
  input  logic [N_BTN-1:0] BTN_IN,
  output logic             BUS_INTERRUPT_RAISE,
  input  logic             BUS_INTERRUPT_ACK
);

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] r_event;
  logic [N_BTN-1:0] r_irq_en;
  logic [7:0]       r_count;
  logic             r_raise;
  logic             r_rd_en;
  logic [7:0]       r_rd_data;

  logic [7:0]       w_off;
  logic             w_in_win;
  logic             w_wr;
  logic [N_BTN-1:0] w_w1c;
  logic [7:0]       w_rd_mux;

  for (genvar g = 0; g < N_BTN; g++) begin : g_flt
    debounce_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_flt (
      .i_clk  (CLK),
      .i_reset(RESET),
      .i_btn  (BTN_IN[g]),
      .o_level(w_level[g]),
      .o_press(w_press[g])
    );
  end

  // Window test by subtraction so the base need not be 4-byte aligned
  assign w_off    = BUS_ADDR - BASE_ADDR;
  assign w_in_win = (w_off < 8'd4);
  assign w_wr     = w_in_win & BUS_WE;

  // Register select for reads and the write-one-to-clear mask for EVENT
  always_comb begin
    w_rd_mux = 8'd0;
    w_w1c    = {N_BTN{1'b0}};
    case (w_off[1:0])
      OFF_LEVEL:  w_rd_mux = 8'(w_level);
      OFF_EVENT:  w_rd_mux = 8'(r_event);
      OFF_IRQ_EN: w_rd_mux = 8'(r_irq_en);
      OFF_COUNT:  w_rd_mux = r_count;
      default:    w_rd_mux = 8'd0;
    endcase
    if (w_wr && (w_off[1:0] == OFF_EVENT)) begin
      w_w1c = BUS_DATA[N_BTN-1:0];
    end else begin
      w_w1c = {N_BTN{1'b0}};
    end
  end

  // Register file, interrupt flop and read-data capture
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_event   <= {N_BTN{1'b0}};
      r_irq_en  <= {N_BTN{1'b0}};
      r_count   <= 8'd0;
      r_raise   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_data <= 8'd0;
    end else begin
      r_event <= (r_event & ~w_w1c) | w_press;
      if (w_wr && (w_off[1:0] == OFF_IRQ_EN)) begin
        r_irq_en <= BUS_DATA[N_BTN-1:0];
      end else begin
        r_irq_en <= r_irq_en;
      end
      r_count <= ((w_wr && (w_off[1:0] == OFF_COUNT)) ? 8'd0 : r_count)
                 + count_ones(8'(w_press));
      // A new enabled press outranks a same-cycle acknowledge
      if (|(w_press & r_irq_en)) begin
        r_raise <= 1'b1;
      end else if (BUS_INTERRUPT_ACK) begin
        r_raise <= 1'b0;
      end else begin
        r_raise <= r_raise;
      end
      r_rd_en   <= w_in_win & ~BUS_WE;
      r_rd_data <= w_rd_mux;
    end
  end

  assign BUS_DATA            = r_rd_en ? r_rd_data : 8'bzzzz_zzzz;
  assign BUS_INTERRUPT_RAISE = r_raise;

endmodule

// File: doc/button_io.md
# button_io

Bus-mapped push-button peripheral for the processor system bus, alongside the timer, seven-segment and mouse peripherals. It synchronises and debounces the board buttons and latches press (rising-edge) events into a sticky register. It raises a processor interrupt on enabled events, so button handling moves into software instead of the ad-hoc debounce logic at top level.

## Interface
- `BASE_ADDR`, 8'hE0: base of the 4-byte register window.
- `N_BTN`, 2: number of buttons, 1..8.
- `DEBOUNCE_CYCLES`, 65535: consecutive stable cycles required to accept a level change, ≥2.
- `CNT_W`, 16: debounce counter width, must hold `DEBOUNCE_CYCLES`.

Ports:
- `CLK` in 1: system clock, all logic on rising edge.
- `RESET` in 1: synchronous, active-high.
- `BUS_DATA` inout 8: shared data bus, driven only during this block's read cycle, otherwise high-Z.
- `BUS_ADDR` in 8: bus address.
- `BUS_WE` in 1: bus write strobe.
- `BTN_IN` in N_BTN: raw asynchronous button pins, active-high.
- `BUS_INTERRUPT_RAISE` out 1: interrupt request to the processor.
- `BUS_INTERRUPT_ACK` in 1: one-cycle acknowledge from the processor.

## Operation
Register map (offset from BASE_ADDR; unused upper bits read 0, writes ignored):
- +0 `LEVEL` (RO): debounced button levels.
- +1 `EVENT` (R/W1C): sticky press flags. A 1 written clears that bit.
- +2 `IRQ_EN` (RW): per-button interrupt enable.
- +3 `COUNT` (RO): 8-bit wrapping count of all accepted presses. Any write clears it to 0.

Per-button filter:
- 2-flop synchroniser on `BTN_IN[i]`.
- Counter is reset to 0 whenever the synchronised input equals the debounced level.
- Otherwise the counter increments.
- When the counter reaches `DEBOUNCE_CYCLES-1` while still differing: the debounced level toggles and the counter clears.
- A one-cycle `press[i]` pulse is produced on a debounced 0→1 transition. Release produces no event.

Event and interrupt logic:
- `press[i]` sets `EVENT[i]` and increments `COUNT`. If two or more presses occur in the same cycle, `COUNT` adds the number of presses, modulo 256.
- `BUS_INTERRUPT_RAISE` is set on any cycle with `press & IRQ_EN` nonzero.
- It is cleared on `BUS_INTERRUPT_ACK`.
- It is not re-raised by events that are already pending. Software clears `EVENT` itself.

Bus read:
- Address in window with `BUS_WE`=0: the register value is captured on the same edge and driven onto `BUS_DATA` for exactly the following cycle (1-cycle read latency).
- Otherwise `BUS_DATA` is high-Z.

Bus write:
- Address in window with `BUS_WE`=1: takes effect on that edge.

Boundary and simultaneous cases:
- W1C on a bit in the same cycle as a new press on that bit: the bit stays 1 (set wins).
- ACK in the same cycle as a new enabled press: RAISE stays 1 (set wins).
- An `IRQ_EN` write takes effect for presses from the next cycle on. Enabling a bit whose event is already pending does not raise.
- A glitch shorter than `DEBOUNCE_CYCLES` produces no level change.
- Any mid-bounce return to the debounced level restarts the count.
- `COUNT` wraps from 255 to 0 silently.

## Timing
- Reset values: `LEVEL`, `EVENT`, `IRQ_EN` and `COUNT` are 0. Synchroniser flops and counters are 0. `BUS_INTERRUPT_RAISE` is 0. The bus driver is released (`BUS_DATA` high-Z).
- Reset mid-debounce discards the partial count. A button held through reset is accepted as a press `DEBOUNCE_CYCLES`+2 cycles after reset deasserts.
- Pin rise to `press` pulse: 2 (synchroniser) + `DEBOUNCE_CYCLES` cycles.
- `EVENT`, `COUNT` and `RAISE` update on the edge after the `press` pulse.
- RAISE falls on the edge after the ACK cycle.

## Structure
- Package `button_io_pkg`: register offsets (`OFF_LEVEL`=0, `OFF_EVENT`=1, `OFF_IRQ_EN`=2, `OFF_COUNT`=3) and the default `BASE_ADDR`.
- Sub-module `debounce_filter`, one instance per button: synchroniser, counter, level and press pulse. `button_io` holds the registers, bus decode, tristate driver and interrupt flop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `N_BTN`=2.
1. Hold `BTN_IN`=2'b01 for 10 cycles. `press[0]` pulses 6 cycles after the rise. Reading +1 gives 8'h01, reading +0 gives 8'h01, reading +3 gives 8'h01.
2. Pulse `BTN_IN[1]` high for 3 cycles, then low. `LEVEL`, `EVENT` and `COUNT` remain 0. No RAISE.
3. Write `IRQ_EN`=8'h02, then press button 1. RAISE goes to 1. Assert ACK for 1 cycle: RAISE is 0 on the next edge. Reading `EVENT` still gives 8'h02.
4. Write 8'h02 to +1 on the same cycle as a new press-1 pulse. `EVENT` reads 8'h02. Repeat without the press: `EVENT` reads 8'h00.
5. Preload `COUNT` to 255 by 255 presses, then press both buttons simultaneously. `COUNT` reads 8'h01.
6. Assert RESET mid-debounce with RAISE=1. After reset all registers read 0, RAISE=0, and `BUS_DATA` is high-Z on non-matching addresses.
